dm_responder: RTL and testbench
===============================

// Module: dm_responder
// PURPOSE
//  Data-memory responder for the pipelined MIPS core: services the core's load/store port.
//  Every committed store is pushed into a trace FIFO as {pc, addr, word} for the bench/logger.
//  Sits beside the core in top-level mips; the memory-side counterpart of the core's store/load initiator.
// PARAMETERS
//  ADDR_WIDTH   10  word-address bits; memory holds 2**ADDR_WIDTH 32-bit words
//  TRACE_DEPTH  4   store-trace FIFO entries (power of 2, >=2)
// PORTS
//  clk        in   1   rising-edge clock, sole clock domain
//  reset      in   1   synchronous, active-low: reset==0 at a clk edge resets the block
//  req_valid  in   1   core presents a memory request
//  req_ready  out  1   request accepted this cycle when req_valid && req_ready
//  req_we     in   1   1=store, 0=load
//  req_addr   in   32  byte address; bits [1:0] ignored
//  req_be     in   4   store byte enables; be[i] writes lane [8i+7:8i]
//  req_wdata  in   32  store data, lane-aligned
//  req_pc     in   32  PC of the requesting instruction (trace only)
//  rsp_valid  out  1   load data valid (one-cycle pulse)
//  rsp_rdata  out  32  load data
//  trc_valid  out  1   trace FIFO head valid
//  trc_ready  in   1   consumer pops head when trc_valid && trc_ready
//  trc_pc     out  32  head entry PC
//  trc_addr   out  32  head entry word-aligned byte address ({..., 2'b00})
//  trc_data   out  32  head entry full word after the store merge
// BEHAVIOUR
//  Reset: every memory word=0; rsp_valid=0, rsp_rdata=0; FIFO empty, trc_valid=0, trc_* =0.
//   Reset overrides any in-flight load (response dropped) and any same-cycle accept/pop.
//  Indexing: word = req_addr[ADDR_WIDTH+1:2]; upper bits discarded (aliasing wrap, no error).
//  req_ready = !(req_we && full); full derived from registered count only (no trc_ready path).
//   Loads are never stalled; stores stall while FIFO full, even if a pop occurs that cycle.
//  Store accept (edge N): mem[word] = per-lane merge(old, req_wdata, req_be);
//   same edge pushes {req_pc, aligned addr, merged word}; be==0 still pushes (data=old word).
//  Load accept (edge N): rsp_valid=1 and rsp_rdata=mem[word] after edge N (latency 1);
//   rsp_valid=0 the next cycle unless another load accepted; rsp_rdata holds its last value.
//  Store at edge N then load same word at edge N+1: load returns the merged word.
//  FIFO: count 0..TRACE_DEPTH, circular rd/wr pointers wrap at TRACE_DEPTH.
//   push only (not full): count+1; pop only (trc_valid): count-1;
//   push+pop same edge (count in 1..DEPTH-1): count unchanged, order preserved;
//   pop with count==0 ignored; trc_* show head combinationally from storage.
//  No X on outputs after first reset edge; req_* ignored when req_valid=0.
// TESTING
//  1. reset=0 2 cycles, release; store be=F addr 0x10 data 0xDEADBEEF pc 0x3000, then load 0x10
//     -> rsp_valid 1 cycle after load accept, rdata 0xDEADBEEF; trace {0x3000,0x10,0xDEADBEEF}.
//  2. word 0x20=0x11223344; store be=4'b0101 wdata 0xAABBCCDD -> load returns 0x11BB33DD,
//     trace data 0x11BB33DD; store be=0 -> memory unchanged, trace entry still pushed.
//  3. trc_ready=0, 4 stores (DEPTH=4) -> 5th store sees req_ready=0; load still accepted;
//     raise trc_ready 1 cycle -> 5th store accepted next cycle, entries pop in order.
//  4. count=2, store accepted while trc_ready=1 -> count stays 2, FIFO order intact;
//     full FIFO + trc_ready=1 + store -> store held, count 3 next cycle.
//  5. store to 0x1000 (ADDR_WIDTH=10) -> load from 0x0 returns same word; trace addr 0x1000.
//  6. load accepted then reset=0 at next edge -> rsp_valid 0, FIFO empty, load of 0x10 returns 0.

Source files
------------

// File: rtl/dm_responder.sv
// Data-memory responder for the pipelined MIPS core: single-cycle word memory with a
// one-cycle load response and a store-trace FIFO recording {pc, addr, merged word}.
module dm_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int TRACE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        trc_valid,
    input  logic        trc_ready,
    output logic [31:0] trc_pc,
    output logic [31:0] trc_addr,
    output logic [31:0] trc_data
);

    localparam int              PTR_W     = $clog2(TRACE_DEPTH);
    localparam int              MEM_WORDS = 2 ** ADDR_WIDTH;
    localparam logic [PTR_W:0]  FULL_CNT  = (PTR_W + 1)'(TRACE_DEPTH);

    logic [31:0]           r_mem [MEM_WORDS];
    logic [31:0]           r_trc_pc   [TRACE_DEPTH];
    logic [31:0]           r_trc_addr [TRACE_DEPTH];
    logic [31:0]           r_trc_data [TRACE_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_count;
    logic                  r_rsp_valid;
    logic [31:0]           r_rsp_rdata;

    logic [ADDR_WIDTH-1:0] w_word;
    logic                  w_full;
    logic                  w_store;
    logic                  w_load;
    logic                  w_pop;
    logic [31:0]           w_old;
    logic [31:0]           w_merged;
    logic                  w_unused;

    function automatic logic [31:0] f_merge(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    // Byte-offset bits carry no meaning for a word memory.
    assign w_unused  = &{1'b0, req_addr[1:0]};

    assign w_word    = req_addr[ADDR_WIDTH+1:2];
    assign w_full    = (r_count == FULL_CNT);
    assign req_ready = !(req_we && w_full);
    assign w_store   = req_valid && req_we && !w_full;
    assign w_load    = req_valid && !req_we;
    assign w_old     = r_mem[w_word];
    assign w_merged  = f_merge(w_old, req_wdata, req_be);

    assign trc_valid = (r_count != '0);
    assign w_pop     = trc_valid && trc_ready;
    assign trc_pc    = r_trc_pc[r_rd_ptr];
    assign trc_addr  = r_trc_addr[r_rd_ptr];
    assign trc_data  = r_trc_data[r_rd_ptr];

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_store) begin
            r_mem[w_word] <= w_merged;
        end
    end

    // Load data reads the pre-edge contents; a store cannot share the cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_load;
            if (w_load) begin
                r_rsp_rdata <= w_old;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < TRACE_DEPTH; i++) begin
                r_trc_pc[i]   <= '0;
                r_trc_addr[i] <= '0;
                r_trc_data[i] <= '0;
            end
        end else begin
            if (w_store) begin
                r_trc_pc[r_wr_ptr]   <= req_pc;
                r_trc_addr[r_wr_ptr] <= {req_addr[31:2], 2'b00};
                r_trc_data[r_wr_ptr] <= w_merged;
                r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: directed scenarios plus random traffic against a
// queue/array reference model; a negedge monitor checks load responses and trace heads.
module tb_dm_responder;

    localparam int AW    = 10;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_be = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] req_pc = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        trc_valid;
    logic        trc_ready = 1'b0;
    logic [31:0] trc_pc;
    logic [31:0] trc_addr;
    logic [31:0] trc_data;

    always #5 clk = ~clk;

    dm_responder #(.ADDR_WIDTH(AW), .TRACE_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .req_pc    (req_pc),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .trc_valid (trc_valid),
        .trc_ready (trc_ready),
        .trc_pc    (trc_pc),
        .trc_addr  (trc_addr),
        .trc_data  (trc_data)
    );

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] mem_m [int];
    logic [31:0] exp_rsp [$];
    logic [95:0] exp_trc [$];
    logic        mon_en = 1'b0;
    logic [31:0] last_rdata = '0;
    logic        last_ready = 1'b0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: mid-cycle, compare whatever the DUT presents with the scoreboard heads.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("rsp_valid", rsp_valid, exp_rsp.size() != 0);
            if (exp_rsp.size() != 0) begin
                logic [31:0] e;
                e = exp_rsp.pop_front();
                if (rsp_valid) chk("rsp_rdata", rsp_rdata, e);
                last_rdata = e;
            end else if (!rsp_valid) begin
                chk("rsp_hold", rsp_rdata, last_rdata);
            end
            chk("trc_valid", trc_valid, exp_trc.size() != 0);
            if (trc_valid && exp_trc.size() != 0) begin
                chk("trc_head", {trc_pc, trc_addr, trc_data}, exp_trc[0]);
                if (trc_ready) void'(exp_trc.pop_front());
            end
        end
    end

    always @(posedge clk) if (!reset) last_rdata = '0;

    // One request cycle: called at posedge+1, returns at the next posedge+1.
    task automatic cyc(input logic v, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd, input logic [31:0] pc,
                       input logic trdy, input logic rn);
        logic        exp_ready;
        logic        acc;
        int          w;
        logic [31:0] old_w;
        logic [31:0] nw;
        req_valid = v; req_we = we; req_addr = addr; req_be = be;
        req_wdata = wd; req_pc = pc; trc_ready = trdy; reset = rn;
        #1;
        exp_ready  = !(we && exp_trc.size() == DEPTH);
        last_ready = req_ready;
        if (mon_en) chk("req_ready", req_ready, exp_ready);
        acc = v && exp_ready && rn;
        @(posedge clk);
        if (!rn) begin
            mem_m.delete();
            exp_trc.delete();
            exp_rsp.delete();
        end else if (acc) begin
            w     = int'(addr[AW+1:2]);
            old_w = mem_m.exists(w) ? mem_m[w] : 32'h0;
            if (we) begin
                nw = old_w;
                for (int i = 0; i < 4; i++) if (be[i]) nw[8*i +: 8] = wd[8*i +: 8];
                mem_m[w] = nw;
                exp_trc.push_back({pc, addr[31:2], 2'b00, nw});
            end else begin
                exp_rsp.push_back(old_w);
            end
        end
        #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                      input logic [31:0] pc, input logic trdy);
        cyc(1'b1, 1'b1, a, be, d, pc, trdy, 1'b1);
    endtask

    task automatic ld(input logic [31:0] a, input logic trdy);
        cyc(1'b1, 1'b0, a, 4'h0, 32'h0, 32'h0, trdy, 1'b1);
    endtask

    task automatic idle(input int n, input logic trdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, trdy, 1'b1);
    endtask

    initial begin
        @(posedge clk); #1;
        cyc(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        mon_en = 1'b1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_trc_valid", trc_valid, 0);
        chk("rst_trc_fields", {trc_pc, trc_addr, trc_data}, 0);

        // Basic store then load.
        st(32'h10, 4'hF, 32'hDEADBEEF, 32'h3000, 1'b0);
        ld(32'h10, 1'b0);
        chk("t1_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("t1_trace", {trc_pc, trc_addr, trc_data}, {32'h3000, 32'h10, 32'hDEADBEEF});
        idle(2, 1'b1);

        // Partial byte-enable merge and be==0 store.
        st(32'h20, 4'hF, 32'h11223344, 32'h3004, 1'b1);
        st(32'h20, 4'b0101, 32'hAABBCCDD, 32'h3008, 1'b1);
        ld(32'h20, 1'b1);
        chk("t2_merge", rsp_rdata, 32'h11BB33DD);
        st(32'h20, 4'h0, 32'hFFFFFFFF, 32'h300C, 1'b0);
        chk("t2_be0_trace", trc_data, 32'h11BB33DD);
        ld(32'h20, 1'b1);
        chk("t2_be0_mem", rsp_rdata, 32'h11BB33DD);
        idle(3, 1'b1);

        // Full FIFO stalls stores, not loads; a pop frees a slot for the next cycle.
        for (int i = 0; i < DEPTH; i++) st(32'h40 + 4*i, 4'hF, 32'hA0 + i, 32'h4000 + 4*i, 1'b0);
        st(32'h50, 4'hF, 32'hB5, 32'h4010, 1'b0);
        chk("t3_stall", last_ready, 0);
        ld(32'h44, 1'b0);
        chk("t3_load_ok", rsp_rdata, 32'hA1);
        st(32'h50, 4'hF, 32'hB5, 32'h4010, 1'b1);
        chk("t3_stall_pop", last_ready, 0);
        st(32'h50, 4'hF, 32'hB5, 32'h4010, 1'b0);
        chk("t3_accept", last_ready, 1);
        idle(DEPTH + 1, 1'b1);

        // Simultaneous push and pop, then full plus pop plus store.
        st(32'h60, 4'hF, 32'h61, 32'h5000, 1'b0);
        st(32'h64, 4'hF, 32'h62, 32'h5004, 1'b0);
        st(32'h68, 4'hF, 32'h63, 32'h5008, 1'b1);
        st(32'h6C, 4'hF, 32'h64, 32'h500C, 1'b0);
        st(32'h70, 4'hF, 32'h65, 32'h5010, 1'b0);
        st(32'h74, 4'hF, 32'h66, 32'h5014, 1'b1);
        chk("t4_full_hold", last_ready, 0);
        st(32'h74, 4'hF, 32'h66, 32'h5014, 1'b0);
        chk("t4_after_pop", last_ready, 1);
        idle(DEPTH + 1, 1'b1);

        // Address aliasing beyond the memory size.
        st(32'h1000, 4'hF, 32'hCAFEF00D, 32'h6000, 1'b0);
        chk("t5_trace_addr", trc_addr, 32'h1000);
        ld(32'h0, 1'b1);
        chk("t5_alias", rsp_rdata, 32'hCAFEF00D);
        idle(2, 1'b1);

        // Reset drops an in-flight load response and clears memory.
        st(32'h10, 4'hF, 32'h12345678, 32'h7000, 1'b0);
        ld(32'h10, 1'b0);
        cyc(1'b1, 1'b0, 32'h10, 0, 0, 0, 1'b1, 1'b0);
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_rsp_rdata", rsp_rdata, 0);
        chk("t6_trc_valid", trc_valid, 0);
        ld(32'h10, 1'b0);
        chk("t6_cleared", {rsp_valid, rsp_rdata}, {1'b1, 32'h0});

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            cyc(1'b1 & ($urandom_range(0, 3) != 0), 1'($urandom), a, 4'($urandom), $urandom,
                $urandom, 1'($urandom_range(0, 2) != 0), ($urandom_range(0, 299) != 0));
        end
        idle(DEPTH + 2, 1'b1);
        chk("end_trc_empty", trc_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
